// File: rtl/apb_pkt_router.sv
// Serial packet router: deserialises PKT_W-bit packets, buffers one in a hold
// register, optionally swaps the top two quarters, and reserialises onto the
// ports enabled in PORT_EN. Control and status registers sit behind APB.
// Latency: the first output bit is visible in the cycle after the edge that
//   moves the completed packet from hold into the output shifter.
// Backpressure: none on APB (pready=1); a completed packet is dropped
//   (drop_cnt) when hold is still occupied and not draining.
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   data_in, valid_in              serial input bit (MSB first) + qualifier
//   paddr/psel/penable/pwrite/pwdata  APB request; prdata registered, pready=1
//   out_port[N_PORTS-1:0]          per-port serial output bit
//   valid_out                      output serialisation in progress
module apb_pkt_router #(
    parameter int         PKT_W       = 64,
    parameter int         N_PORTS     = 4,
    parameter logic [7:0] CHIP_ID_VAL = 8'hAA
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               data_in,
    input  logic               valid_in,
    input  logic [31:0]        paddr,
    input  logic               psel,
    input  logic               penable,
    input  logic               pwrite,
    input  logic [31:0]        pwdata,
    output logic [31:0]        prdata,
    output logic               pready,
    output logic [N_PORTS-1:0] out_port,
    output logic               valid_out
);

    localparam int            CW       = $clog2(PKT_W);
    localparam int            Q        = PKT_W / 4;
    localparam logic [CW-1:0] CNT_LAST = CW'(PKT_W - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Registers
    logic               chip_en;
    logic               swap_en;
    logic [N_PORTS-1:0] port_en;
    logic [7:0]         chip_id;
    logic [15:0]        pkt_cnt;
    logic [7:0]         drop_cnt;

    // Datapath
    logic [PKT_W-1:0]   in_sr;
    logic [CW-1:0]      in_cnt;
    logic [PKT_W-1:0]   hold;
    logic               hold_valid;
    logic [PKT_W-1:0]   out_sr;
    logic [CW-1:0]      out_cnt;

    // APB decode
    logic        acc, wr_acc, rd_acc;
    logic [1:0]  reg_sel;
    logic        ctrl_wr, ctrl_clear, port_wr, status_wr;
    logic [31:0] rd_mux;

    // Packet flow
    logic             in_shift_en, in_last;
    logic [PKT_W-1:0] pkt_done;
    logic             out_last, drain, hold_load, pkt_drop;
    logic [PKT_W-1:0] xform;

    logic unused;

    assign pready = 1'b1;
    assign unused = ^{paddr, pwdata, in_sr[PKT_W-1]};

    assign acc        = psel & penable;
    assign wr_acc     = acc & pwrite;
    assign rd_acc     = acc & ~pwrite;
    assign reg_sel    = paddr[3:2];
    assign ctrl_wr    = wr_acc && (reg_sel == 2'd0);
    assign port_wr    = wr_acc && (reg_sel == 2'd2);
    assign status_wr  = wr_acc && (reg_sel == 2'd3);
    // Any CTRL write leaving chip_en low flushes all in-flight packet state.
    assign ctrl_clear = ctrl_wr & ~pwdata[0];

    assign in_shift_en = chip_en & valid_in;
    assign in_last     = in_shift_en && (in_cnt == CNT_LAST);
    assign pkt_done    = {in_sr[PKT_W-2:0], data_in};

    assign out_last  = (state_q == SHIFT) && (out_cnt == CNT_LAST);
    // Hold hands over while the shifter is idle or on its final bit, so
    // consecutive packets leave without a gap in valid_out.
    assign drain     = hold_valid && ((state_q == IDLE) || out_last);
    assign hold_load = in_last && (!hold_valid || drain);
    assign pkt_drop  = in_last && hold_valid && !drain;

    assign xform = swap_en ? {hold[PKT_W-Q-1 -: Q], hold[PKT_W-1 -: Q], hold[PKT_W-2*Q-1:0]}
                           : hold;

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            2'd0: rd_mux = {30'd0, swap_en, chip_en};
            2'd1: rd_mux = {24'd0, chip_id};
            2'd2: rd_mux = 32'(port_en);
            2'd3: rd_mux = {8'd0, drop_cnt, pkt_cnt};
        endcase
    end

    // Output FSM: state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (drain) state_d = SHIFT;
            SHIFT: if (out_last && !drain) state_d = IDLE;
        endcase
        if (ctrl_clear) begin
            state_d = IDLE;
        end
    end

    // Output FSM: outputs
    always_comb begin
        valid_out = (state_q == SHIFT);
        out_port  = port_en & {N_PORTS{valid_out & chip_en & out_sr[PKT_W-1]}};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            chip_en    <= 1'b0;
            swap_en    <= 1'b0;
            port_en    <= N_PORTS'(1);
            chip_id    <= CHIP_ID_VAL;
            pkt_cnt    <= '0;
            drop_cnt   <= '0;
            prdata     <= '0;
            in_sr      <= '0;
            in_cnt     <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
            out_sr     <= '0;
            out_cnt    <= '0;
        end else begin
            // APB register side
            if (ctrl_wr) begin
                chip_en <= pwdata[0];
                swap_en <= pwdata[1];
            end
            if (port_wr) begin
                port_en <= pwdata[N_PORTS-1:0];
            end
            if (rd_acc) begin
                prdata <= rd_mux;
            end

            // Input deserialiser
            if (ctrl_clear) begin
                in_cnt <= '0;
            end else if (in_shift_en) begin
                in_sr  <= pkt_done;
                in_cnt <= in_last ? '0 : in_cnt + CNT_ONE;
            end

            // One-deep hold buffer
            if (ctrl_clear) begin
                hold_valid <= 1'b0;
            end else if (hold_load) begin
                hold       <= pkt_done;
                hold_valid <= 1'b1;
            end else if (drain) begin
                hold_valid <= 1'b0;
            end

            // Output serialiser; swap is applied once at load time
            if (drain) begin
                out_sr  <= xform;
                out_cnt <= '0;
            end else if (state_q == SHIFT) begin
                out_sr  <= {out_sr[PKT_W-2:0], 1'b0};
                out_cnt <= out_cnt + CNT_ONE;
            end

            // Counters; a STATUS write wins over a same-edge increment
            if (status_wr) begin
                pkt_cnt <= '0;
            end else if (out_last) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
            if (status_wr) begin
                drop_cnt <= '0;
            end else if (pkt_drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_apb_pkt_router.sv
// Directed bench for apb_pkt_router with a packet-level reference model.
module tb_apb_pkt_router;

    localparam int PKT_W   = 64;
    localparam int N_PORTS = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               data_in;
    logic               valid_in;
    logic [31:0]        paddr;
    logic               psel;
    logic               penable;
    logic               pwrite;
    logic [31:0]        pwdata;
    logic [31:0]        prdata;
    logic               pready;
    logic [N_PORTS-1:0] out_port;
    logic               valid_out;

    apb_pkt_router #(
        .PKT_W      (PKT_W),
        .N_PORTS    (N_PORTS),
        .CHIP_ID_VAL(8'hAA)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .valid_in (valid_in),
        .paddr    (paddr),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .out_port (out_port),
        .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (packet/queue level) ----------------
    bit          model_ok = 0;
    logic [1:0]  m_ctrl;
    logic [3:0]  m_pen;
    logic [15:0] m_pkt;
    logic [7:0]  m_drop;
    logic [31:0] m_prdata;
    int          m_in_bits;
    logic [63:0] m_in_val;
    logic [63:0] m_hold[$];
    bit          m_out[$];

    function automatic logic [63:0] swap_q(input logic [63:0] p);
        return {p[47:32], p[63:48], p[31:0]};
    endfunction

    function automatic logic [31:0] m_reg(input logic [1:0] a);
        case (a)
            2'd0:    return {30'd0, m_ctrl};
            2'd1:    return 32'h0000_00AA;
            2'd2:    return {28'd0, m_pen};
            default: return {8'd0, m_drop, m_pkt};
        endcase
    endfunction

    task automatic model_step();
        logic        wr, rd;
        logic [1:0]  a;
        bit          complete, drain;
        logic [63:0] np, hp;
        if (!rst) begin
            m_ctrl = 0; m_pen = 4'd1; m_pkt = 0; m_drop = 0; m_prdata = 0;
            m_in_bits = 0; m_hold.delete(); m_out.delete();
            model_ok = 1;
            return;
        end
        if (!model_ok) return;
        wr = psel && penable && pwrite;
        rd = psel && penable && !pwrite;
        a  = paddr[3:2];
        if (rd) m_prdata = m_reg(a);
        complete = 0;
        np = m_in_val;
        if (m_ctrl[0] && valid_in) begin
            np = {m_in_val[62:0], data_in};
            m_in_val = np;
            if (m_in_bits == PKT_W - 1) begin
                complete = 1;
                m_in_bits = 0;
            end else begin
                m_in_bits++;
            end
        end
        drain = (m_hold.size() > 0) && (m_out.size() <= 1);
        if (m_out.size() > 0) begin
            void'(m_out.pop_front());
            if (m_out.size() == 0) m_pkt++;
        end
        if (drain) begin
            hp = m_hold.pop_front();
            if (m_ctrl[1]) hp = swap_q(hp);
            for (int i = PKT_W - 1; i >= 0; i--) m_out.push_back(hp[i]);
        end
        if (complete) begin
            if (m_hold.size() == 0) m_hold.push_back(np);
            else if (m_drop != 8'hFF) m_drop++;
        end
        if (wr) begin
            case (a)
                2'd0: begin
                    m_ctrl = pwdata[1:0];
                    if (!pwdata[0]) begin
                        m_in_bits = 0; m_hold.delete(); m_out.delete();
                    end
                end
                2'd2: m_pen = pwdata[3:0];
                2'd3: begin m_pkt = 0; m_drop = 0; end
                default: ;
            endcase
        end
    endtask

    always @(posedge clk) model_step();

    // ---------------- per-cycle compare + observation ----------------
    int          cap_port = 2;
    logic [63:0] cap = '0;
    int          cap_n = 0;
    int          run_len = 0;
    int          last_run = 0;
    int          ne_cnt = 0;
    int          nz_cnt = 0;

    always @(negedge clk) begin
        logic       ev;
        logic [3:0] ep;
        if (model_ok) begin
            ev = (m_out.size() > 0);
            ep = (ev && m_ctrl[0] && m_out[0]) ? m_pen : 4'd0;
            chk("valid_out", {63'd0, valid_out}, {63'd0, ev});
            chk("out_port", {60'd0, out_port}, {60'd0, ep});
            chk("prdata", {32'd0, prdata}, {32'd0, m_prdata});
            chk("pready", {63'd0, pready}, 64'd1);
            if (valid_out) begin
                cap = {cap[62:0], out_port[cap_port]};
                cap_n++;
                run_len++;
                if (out_port != 4'h0 && out_port != 4'hF) ne_cnt++;
                if (out_port != 4'h0) nz_cnt++;
            end else if (run_len != 0) begin
                last_run = run_len;
                run_len = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apb_wr(input logic [31:0] addr, input logic [31:0] d);
        psel = 1; penable = 0; pwrite = 1; paddr = addr; pwdata = d;
        tick();
        penable = 1;
        tick();
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic apb_rd(input logic [31:0] addr, output logic [31:0] d);
        psel = 1; penable = 0; pwrite = 0; paddr = addr;
        tick();
        penable = 1;
        tick();
        psel = 0; penable = 0;
        @(negedge clk);
        d = prdata;
    endtask

    task automatic send_bits(input logic [63:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            data_in = p[63 - i];
            valid_in = 1;
            tick();
        end
        valid_in = 0;
        data_in = 0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((valid_out || m_out.size() > 0 || m_hold.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        tick();
        chk("wait_idle_in_budget", {63'd0, n < budget}, 64'd1);
    endtask

    task automatic clear_obs();
        cap = '0; cap_n = 0; last_run = 0; ne_cnt = 0; nz_cnt = 0;
    endtask

    logic [31:0] rv;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0; data_in = 0; valid_in = 0; paddr = 0;
        psel = 0; penable = 0; pwrite = 0; pwdata = 0;
        tick(); tick();
        chk("reset_valid_out", {63'd0, valid_out}, 64'd0);
        chk("reset_out_port", {60'd0, out_port}, 64'd0);
        chk("reset_prdata", {32'd0, prdata}, 64'd0);
        rst = 1;
        tick();

        // Register reset values
        apb_rd(32'h4, rv); chk("rd_chip_id", {32'd0, rv}, 64'hAA);
        apb_rd(32'h8, rv); chk("rd_port_en", {32'd0, rv}, 64'h1);
        apb_rd(32'h0, rv); chk("rd_ctrl", {32'd0, rv}, 64'h0);
        apb_wr(32'h4, 32'h55);
        apb_rd(32'h104, rv); chk("chip_id_ro", {32'd0, rv}, 64'hAA);

        // Single packet to port 2
        apb_wr(32'h8, 32'h4);
        apb_wr(32'h0, 32'h1);
        clear_obs(); cap_port = 2;
        send_bits(64'h0123456789ABCDEF, 64);
        wait_idle(300);
        chk("pass_data", cap, 64'h0123456789ABCDEF);
        chk("pass_valid_cycles", 64'(cap_n), 64'd64);
        apb_rd(32'hC, rv); chk("status_one", {32'd0, rv}, 64'h1);

        // Quarter swap
        apb_wr(32'h0, 32'h3);
        clear_obs();
        send_bits(64'h0123456789ABCDEF, 64);
        wait_idle(300);
        chk("swap_data", cap, 64'h4567012389ABCDEF);

        // Three back-to-back packets, continuous output
        apb_wr(32'h0, 32'h1);
        clear_obs();
        send_bits(64'hDEADBEEF00112233, 64);
        send_bits(64'hA5A5_5A5A_F0F0_0F0F, 64);
        send_bits(64'h8000_0000_0000_0001, 64);
        wait_idle(500);
        chk("b2b_run_len", 64'(last_run), 64'd192);
        chk("b2b_last_pkt", cap, 64'h8000_0000_0000_0001);
        apb_rd(32'hC, rv); chk("status_b2b", {32'd0, rv}, 64'h5);

        // Multicast to all ports, four packets
        apb_wr(32'h8, 32'hF);
        clear_obs();
        send_bits(64'h1111_2222_3333_4444, 64);
        send_bits(64'hFFFF_0000_FFFF_0000, 64);
        send_bits(64'h0F1E_2D3C_4B5A_6978, 64);
        send_bits(64'hC3C3_3C3C_9696_6969, 64);
        wait_idle(600);
        chk("mcast_run_len", 64'(last_run), 64'd256);
        chk("mcast_ports_equal", 64'(ne_cnt), 64'd0);
        apb_rd(32'hC, rv); chk("status_mcast", {32'd0, rv}, 64'h9);

        // PORT_EN=0: packet drains with all ports low
        apb_wr(32'h8, 32'h0);
        clear_obs();
        send_bits(64'hFFFF_FFFF_FFFF_FFFF, 64);
        wait_idle(300);
        chk("porten0_run_len", 64'(last_run), 64'd64);
        chk("porten0_ports_low", 64'(nz_cnt), 64'd0);
        apb_rd(32'hC, rv); chk("status_porten0", {32'd0, rv}, 64'hA);

        // chip_en cleared mid-packet discards the partial packet
        apb_wr(32'h8, 32'h4);
        send_bits(64'hFFFF_FFFF_FFFF_FFFF, 30);
        apb_wr(32'h0, 32'h0);
        apb_wr(32'h0, 32'h1);
        clear_obs(); cap_port = 2;
        send_bits(64'h0123456789ABCDEF, 64);
        wait_idle(300);
        chk("abort_only_new", cap, 64'h0123456789ABCDEF);
        chk("abort_valid_cycles", 64'(cap_n), 64'd64);
        apb_rd(32'hC, rv); chk("status_abort", {32'd0, rv}, 64'hB);

        // STATUS write clears, then reset mid-output
        apb_wr(32'hC, 32'h1234_5678);
        apb_rd(32'hC, rv); chk("status_cleared", {32'd0, rv}, 64'h0);
        send_bits(64'hFFFF_FFFF_FFFF_FFFF, 64);
        tick();
        chk("pre_reset_active", {63'd0, valid_out}, 64'd1);
        repeat (10) tick();
        rst = 0;
        tick();
        chk("mid_reset_valid_out", {63'd0, valid_out}, 64'd0);
        chk("mid_reset_out_port", {60'd0, out_port}, 64'd0);
        rst = 1;
        tick();
        apb_rd(32'h0, rv); chk("post_reset_ctrl", {32'd0, rv}, 64'h0);
        apb_rd(32'h8, rv); chk("post_reset_port_en", {32'd0, rv}, 64'h1);
        apb_rd(32'hC, rv); chk("post_reset_status", {32'd0, rv}, 64'h0);
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
